// File: rtl/axi_st_patgen_pkg.sv
// Shared types and constants for the AXI-ST pattern generator.
package axi_st_patgen_pkg;

    localparam int unsigned SEG_W     = 256;
    localparam int unsigned WORD_W    = 40;
    localparam int unsigned NUM_LANES = 6;

    // Taps 40,38,21,19 (1-indexed) as a mask over bits [39:0]
    localparam logic [WORD_W-1:0] LFSR_TAPS = 40'hA0_0014_0000;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } patgen_state_e;

    // One 256-bit segment: six copies of the word plus its low 16 bits on top
    function automatic logic [SEG_W-1:0] build_seg(input logic [WORD_W-1:0] w);
        return {w[15:0], {NUM_LANES{w}}};
    endfunction

endpackage

// File: rtl/axi_st_patgen_if.sv
// AXI-ST beat channel between the pattern generator (master) and its sink (slave).
interface axi_st_patgen_if #(
    parameter int unsigned PATGEN_MODE = 1
) ();

    logic                                                 axist_valid;
    logic [axi_st_patgen_pkg::SEG_W*PATGEN_MODE-1:0]      axist_tx_data;
    logic [1:0]                                           axist_denable;
    logic                                                 axist_tready;

    modport master (
        output axist_valid,
        output axist_tx_data,
        output axist_denable,
        input  axist_tready
    );

    modport slave (
        input  axist_valid,
        input  axist_tx_data,
        input  axist_denable,
        output axist_tready
    );

endinterface

// File: rtl/axi_st_patgen_word.sv
// Pattern word source: loads the seed and advances by STEP words per accepted beat.
// AXIST_PATGEN_PRBS_EN selects a 40-bit Fibonacci LFSR; otherwise an incrementing counter.
module axi_st_patgen_word
    import axi_st_patgen_pkg::*;
#(
    parameter int unsigned       STEP     = 1,
    parameter logic [WORD_W-1:0] PAT_SEED = 40'h1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     load_i,
    input  logic                     adv_i,
    output logic [WORD_W*STEP-1:0]   words_o
);

    function automatic logic [WORD_W-1:0] next_word(input logic [WORD_W-1:0] w);
`ifdef AXIST_PATGEN_PRBS_EN
        return {w[WORD_W-2:0], ^(w & LFSR_TAPS)};
`else
        return w + WORD_W'(1);
`endif
    endfunction

    logic [WORD_W-1:0] word_q, word_d, word_nxt;

    assign word_nxt = next_word(word_q);

    always_comb begin
        word_d = word_q;
        if (load_i) begin
            word_d = PAT_SEED;
        end else if (adv_i) begin
            word_d = (STEP == 2) ? next_word(word_nxt) : word_nxt;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            word_q <= PAT_SEED;
        end else begin
            word_q <= word_d;
        end
    end

    if (STEP == 2) begin : g_two
        assign words_o = {word_nxt, word_q};
    end else begin : g_one
        assign words_o = word_q;
    end

endmodule

// File: rtl/axi_st_patgen_top.sv
// Transmit-side AXI-ST pattern generator: counted or continuous bursts of 40-bit-word beats.
// Word source is a PRBS LFSR when AXIST_PATGEN_PRBS_EN is defined, else an incrementing counter.
module axi_st_patgen_top
    import axi_st_patgen_pkg::*;
#(
    parameter int unsigned       PATGEN_MODE = 1,
    parameter logic [WORD_W-1:0] PAT_SEED    = 40'h1
) (
    input  logic                          wrclk_i,
    input  logic                          rst_i,
    input  logic                          patgen_en_i,
    input  logic [8:0]                    patgen_cnt_i,
    input  logic                          cntuspatt_en_i,
    axi_st_patgen_if.master               axist,
    output logic [WORD_W*PATGEN_MODE-1:0] patgen_din_o,
    output logic                          patgen_din_wr_o,
    output logic                          patgen_busy_o,
    output logic                          patgen_done_o,
    output logic [8:0]                    beat_count_o
);

    localparam int unsigned DinW    = WORD_W * PATGEN_MODE;
    localparam logic [1:0]  Denable = (PATGEN_MODE == 2) ? 2'b11 : 2'b01;

    patgen_state_e                state_q, state_d;
    logic                         en_prev_q, cont_prev_q;
    logic                         cont_q, cont_d;
    logic                         stop_q, stop_d;
    logic [8:0]                   cnt_q, cnt_d;
    logic [8:0]                   beat_count_q, beat_count_d;
    logic [DinW-1:0]              din_q, din_d;
    logic                         din_wr_q, din_wr_d;
    logic                         en_rise, cont_rise, cont_fall;
    logic                         valid, accept, load;
    logic [DinW-1:0]              words;
    logic [SEG_W*PATGEN_MODE-1:0] beat_data;

    assign en_rise   = patgen_en_i & ~en_prev_q;
    assign cont_rise = cntuspatt_en_i & ~cont_prev_q;
    assign cont_fall = ~cntuspatt_en_i & cont_prev_q;
    assign valid     = (state_q == StRun);
    assign accept    = valid & axist.axist_tready;

    axi_st_patgen_word #(
        .STEP     (PATGEN_MODE),
        .PAT_SEED (PAT_SEED)
    ) u_word (
        .clk_i   (wrclk_i),
        .rst_i   (rst_i),
        .load_i  (load),
        .adv_i   (accept),
        .words_o (words)
    );

    for (genvar g = 0; g < PATGEN_MODE; g++) begin : g_seg
        assign beat_data[g*SEG_W +: SEG_W] = build_seg(words[g*WORD_W +: WORD_W]);
    end

    always_comb begin
        state_d      = state_q;
        cont_d       = cont_q;
        stop_d       = stop_q;
        cnt_d        = cnt_q;
        beat_count_d = beat_count_q;
        din_d        = din_q;
        din_wr_d     = 1'b0;
        load         = 1'b0;

        unique case (state_q)
            StIdle: begin
                // A simultaneous rise on both enables starts continuous mode
                if (cont_rise) begin
                    state_d      = StRun;
                    cont_d       = 1'b1;
                    stop_d       = 1'b0;
                    load         = 1'b1;
                    beat_count_d = '0;
                end else if (en_rise) begin
                    state_d      = (patgen_cnt_i == 9'd0) ? StDone : StRun;
                    cont_d       = 1'b0;
                    stop_d       = 1'b0;
                    cnt_d        = patgen_cnt_i;
                    load         = 1'b1;
                    beat_count_d = '0;
                end
            end
            StRun: begin
                if (cont_q && cont_fall) begin
                    stop_d = 1'b1;
                end
                if (accept) begin
                    din_wr_d     = 1'b1;
                    din_d        = words;
                    beat_count_d = (beat_count_q == 9'h1FF) ? beat_count_q
                                                            : beat_count_q + 9'd1;
                    // A stopped continuous burst ends only once its held beat is taken
                    if (cont_q ? (stop_q || cont_fall) : (beat_count_q == cnt_q - 9'd1)) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge wrclk_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            en_prev_q    <= 1'b0;
            cont_prev_q  <= 1'b0;
            cont_q       <= 1'b0;
            stop_q       <= 1'b0;
            cnt_q        <= '0;
            beat_count_q <= '0;
            din_q        <= '0;
            din_wr_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            en_prev_q    <= patgen_en_i;
            cont_prev_q  <= cntuspatt_en_i;
            cont_q       <= cont_d;
            stop_q       <= stop_d;
            cnt_q        <= cnt_d;
            beat_count_q <= beat_count_d;
            din_q        <= din_d;
            din_wr_q     <= din_wr_d;
        end
    end

    assign axist.axist_valid   = valid;
    assign axist.axist_tx_data = valid ? beat_data : '0;
    assign axist.axist_denable = valid ? Denable : 2'b00;

    assign patgen_din_o    = din_q;
    assign patgen_din_wr_o = din_wr_q;
    assign patgen_busy_o   = (state_q == StRun);
    assign patgen_done_o   = (state_q == StDone);
    assign beat_count_o    = beat_count_q;

endmodule
